choose_ref_node_datapath: RTL and testbench
===========================================

Name: choose_ref_node_datapath

Overview:
- Datapath responder for the reference-node selection controller. Services its three requests: data reset (go_reset_data), index load (ld_node_index) and validity judge (go_judge_valid). Returns data_reset_done, done_judge and node_index_valid.
- Clears the shortest-path distance memory to infinity and latches the accepted reference node for the following path-computation stage.

Parameters:
- MAX_NODES, 16, number of graph node slots and distance-memory depth.
- IDX_W, 4, node index width; must satisfy 2^IDX_W >= MAX_NODES.
- DIST_W, 8, distance-memory word width; all-ones encodes infinity.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- program_resetn  in  1  asynchronous, active-low reset.
- go_reset_data  in  1  level request from the controller: clear data; held until data_reset_done is seen.
- ld_node_index  in  1  level: load node_in into the index register every cycle while high.
- go_judge_valid  in  1  level request: judge the loaded index; held until done_judge is seen.
- node_in  in  IDX_W  node index from the switch/keypad input stage.
- node_count  in  IDX_W+1  number of nodes defined by the graph-entry stage.
- node_exists  in  MAX_NODES  bitmap; bit i set means node i was created.
- data_reset_done  out  1  high in CLEAR_DONE.
- done_judge  out  1  high in JUDGE_DONE.
- node_index_valid  out  1  registered verdict; meaningful only while done_judge is high.
- ref_node  out  IDX_W  accepted reference node.
- ref_node_valid  out  1  ref_node holds an accepted value.
- dist_wr_en  out  1  distance-memory write strobe.
- dist_wr_addr  out  IDX_W  distance-memory write address.
- dist_wr_data  out  DIST_W  distance-memory write data; constant all-ones.
- busy  out  1  state is neither IDLE nor a DONE state.

Behaviour:
- Reset (asynchronous, while program_resetn is 0):
  - state goes to IDLE.
  - All registers clear to 0: index register, ref_node, ref_node_valid, node_index_valid, clear counter.
  - All outputs read 0, except dist_wr_data, which is all-ones at all times.
- States: IDLE, CLEAR, CLEAR_DONE, JUDGE_RANGE, JUDGE_EXIST, JUDGE_DONE. All outputs are Moore, decoded from state plus registers.
- Index load: while ld_node_index is high, the index register is loaded with node_in every cycle, in any state. The judge sequence compares against the register value, not node_in.
- IDLE:
  - go_reset_data high goes to CLEAR, loads the counter with 0, and clears ref_node and ref_node_valid.
  - Otherwise, go_judge_valid high goes to JUDGE_RANGE.
  - If both are high, go_reset_data has priority.
- CLEAR:
  - Each cycle: dist_wr_en=1, dist_wr_addr=counter, then the counter increments.
  - Leaving CLEAR: after the write to MAX_NODES-1, go to CLEAR_DONE. Exactly MAX_NODES write cycles, addresses 0..MAX_NODES-1 in order, no gaps or repeats.
  - go_reset_data dropping mid-sweep aborts to IDLE; data_reset_done never asserts.
- CLEAR_DONE: data_reset_done=1, held while go_reset_data stays high; go_reset_data low returns to IDLE. A later go_reset_data rise starts a fresh full sweep.
- JUDGE_RANGE: registers in_range = (node_count != 0) && (index register < node_count), computed at IDX_W+1 width, then goes to JUDGE_EXIST.
- JUDGE_EXIST: node_index_valid <= in_range && node_exists[index register], then goes to JUDGE_DONE. node_exists is never indexed when in_range=0, so an out-of-range index cannot select a bit.
- JUDGE_DONE:
  - done_judge=1, held while go_judge_valid stays high; go_judge_valid low returns to IDLE.
  - On entry, if the verdict is valid: ref_node <= index register and ref_node_valid <= 1.
  - If the verdict is invalid: ref_node and ref_node_valid are unchanged.
- Latency: go_judge_valid first sampled high at edge E0 gives done_judge high after E0+2 edges (3rd rising edge).
- go_judge_valid dropping in JUDGE_RANGE or JUDGE_EXIST aborts to IDLE; ref_node is not updated.
- go_reset_data rising during any judge state is ignored until the datapath returns to IDLE.
- Reset asserted mid-sweep or mid-judge takes effect immediately; partial writes are not resumed.

Test Plan:
- Clear sweep, MAX_NODES=16: go_reset_data held high -> dist_wr_en high for exactly 16 cycles, addresses 0..15, data 0xFF; data_reset_done rises on the next cycle and stays high until go_reset_data drops.
- Valid judge: node_count=5, node_exists=16'h001F, load 3, pulse go_judge_valid -> done_judge on the 3rd edge with node_index_valid=1, ref_node=3, ref_node_valid=1.
- Invalid judges:
  - Out of range: node_count=5, load 7 -> node_index_valid=0; ref_node keeps its previous value 3.
  - Missing node: node_exists=16'h0017, load 3 -> invalid.
  - Empty graph: node_count=0, load 0 -> invalid.
- Abort cases:
  - go_reset_data dropped after 6 writes -> IDLE, no data_reset_done.
  - go_judge_valid dropped in JUDGE_EXIST -> no done_judge, ref_node unchanged.
- Priority and reset:
  - go_reset_data and go_judge_valid raised together in IDLE -> CLEAR entered and ref_node_valid cleared.
  - program_resetn pulsed low mid-CLEAR (asynchronous, between clock edges) -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/choose_ref_node_datapath.sv
// Datapath responder for the reference-node selection controller: sweeps the
// distance memory to infinity and judges/latches the chosen reference node.
module choose_ref_node_datapath #(
    parameter int MAX_NODES = 16,
    parameter int IDX_W     = 4,
    parameter int DIST_W    = 8
) (
    input  logic                 clk,
    input  logic                 program_resetn,
    input  logic                 go_reset_data,
    input  logic                 ld_node_index,
    input  logic                 go_judge_valid,
    input  logic [IDX_W-1:0]     node_in,
    input  logic [IDX_W:0]       node_count,
    input  logic [MAX_NODES-1:0] node_exists,
    output logic                 data_reset_done,
    output logic                 done_judge,
    output logic                 node_index_valid,
    output logic [IDX_W-1:0]     ref_node,
    output logic                 ref_node_valid,
    output logic                 dist_wr_en,
    output logic [IDX_W-1:0]     dist_wr_addr,
    output logic [DIST_W-1:0]    dist_wr_data,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CLEAR_DONE,
        S_JUDGE_RANGE,
        S_JUDGE_EXIST,
        S_JUDGE_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(MAX_NODES - 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     clr_cnt_reg;
    logic [IDX_W-1:0]     ref_node_reg;
    logic                 ref_node_valid_reg;
    logic                 node_index_valid_reg;
    logic                 in_range_reg;

    logic                 in_range_next;
    logic [MAX_NODES-1:0] exist_hit;
    logic                 verdict_next;

    // One-hot match of the index register against each node slot; an index
    // beyond MAX_NODES-1 simply matches nothing.
    generate
        for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_exist
            assign exist_hit[gi] = node_exists[gi] && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign in_range_next = (node_count != '0) && ({1'b0, idx_reg} < node_count);
    assign verdict_next  = in_range_reg && (|exist_hit);

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (go_reset_data) begin
                    state_next = S_CLEAR;
                end else if (go_judge_valid) begin
                    state_next = S_JUDGE_RANGE;
                end
            end
            S_CLEAR: begin
                if (!go_reset_data) begin
                    state_next = S_IDLE;
                end else if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = S_CLEAR_DONE;
                end
            end
            S_CLEAR_DONE: begin
                if (!go_reset_data) begin
                    state_next = S_IDLE;
                end
            end
            S_JUDGE_RANGE: begin
                state_next = go_judge_valid ? S_JUDGE_EXIST : S_IDLE;
            end
            S_JUDGE_EXIST: begin
                state_next = go_judge_valid ? S_JUDGE_DONE : S_IDLE;
            end
            S_JUDGE_DONE: begin
                if (!go_judge_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            idx_reg              <= '0;
            clr_cnt_reg          <= '0;
            ref_node_reg         <= '0;
            ref_node_valid_reg   <= 1'b0;
            node_index_valid_reg <= 1'b0;
            in_range_reg         <= 1'b0;
        end else begin
            if (ld_node_index) begin
                idx_reg <= node_in;
            end
            case (state_reg)
                S_IDLE: begin
                    if (go_reset_data) begin
                        clr_cnt_reg        <= '0;
                        ref_node_reg       <= '0;
                        ref_node_valid_reg <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                end
                S_JUDGE_RANGE: begin
                    in_range_reg <= in_range_next;
                end
                S_JUDGE_EXIST: begin
                    // The reference node is only committed when the judge
                    // actually completes, never on an abort.
                    if (state_next == S_JUDGE_DONE) begin
                        node_index_valid_reg <= verdict_next;
                        if (verdict_next) begin
                            ref_node_reg       <= idx_reg;
                            ref_node_valid_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_reset_done  = (state_reg == S_CLEAR_DONE);
    assign done_judge       = (state_reg == S_JUDGE_DONE);
    assign node_index_valid = node_index_valid_reg;
    assign ref_node         = ref_node_reg;
    assign ref_node_valid   = ref_node_valid_reg;
    assign dist_wr_en       = (state_reg == S_CLEAR);
    assign dist_wr_addr     = dist_wr_en ? clr_cnt_reg : '0;
    assign dist_wr_data     = '1;
    assign busy             = (state_reg == S_CLEAR) || (state_reg == S_JUDGE_RANGE) ||
                              (state_reg == S_JUDGE_EXIST);

endmodule

// File: tb/tb_choose_ref_node_datapath.sv
// Scoreboard bench for choose_ref_node_datapath: drivers queue expected
// memory writes / completions, a negedge monitor pops and compares them.
module tb_choose_ref_node_datapath;

    localparam int MAX_NODES = 16;
    localparam int IDX_W     = 4;
    localparam int DIST_W    = 8;
    localparam int INF       = (1 << DIST_W) - 1;

    localparam int K_WR    = 0;
    localparam int K_RDONE = 1;
    localparam int K_JDONE = 2;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 program_resetn;
    logic                 go_reset_data;
    logic                 ld_node_index;
    logic                 go_judge_valid;
    logic [IDX_W-1:0]     node_in;
    logic [IDX_W:0]       node_count;
    logic [MAX_NODES-1:0] node_exists;
    logic                 data_reset_done;
    logic                 done_judge;
    logic                 node_index_valid;
    logic [IDX_W-1:0]     ref_node;
    logic                 ref_node_valid;
    logic                 dist_wr_en;
    logic [IDX_W-1:0]     dist_wr_addr;
    logic [DIST_W-1:0]    dist_wr_data;
    logic                 busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_ref  = 0;
    int   m_refv = 0;
    logic prev_rd = 1'b0;
    logic prev_dj = 1'b0;

    choose_ref_node_datapath #(
        .MAX_NODES(MAX_NODES), .IDX_W(IDX_W), .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .program_resetn(program_resetn), .go_reset_data(go_reset_data),
        .ld_node_index(ld_node_index), .go_judge_valid(go_judge_valid),
        .node_in(node_in), .node_count(node_count), .node_exists(node_exists),
        .data_reset_done(data_reset_done), .done_judge(done_judge),
        .node_index_valid(node_index_valid), .ref_node(ref_node),
        .ref_node_valid(ref_node_valid), .dist_wr_en(dist_wr_en),
        .dist_wr_addr(dist_wr_addr), .dist_wr_data(dist_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    task automatic push(input int kind, input int a, input int b, input int c);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic pop_expect(input int kind, output exp_t e);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
            e.kind = -1; e.a = 0; e.b = 0; e.c = 0;
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
        end
    endtask

    // Monitor: decoupled from stimulus, compares whatever the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (program_resetn) begin
            if (dist_wr_en) begin
                pop_expect(K_WR, e);
                if (e.kind == K_WR) begin
                    chk("wr_addr", int'(dist_wr_addr), e.a);
                    chk("wr_data", int'(dist_wr_data), INF);
                end
            end
            if (data_reset_done && !prev_rd) begin
                pop_expect(K_RDONE, e);
            end
            if (done_judge && !prev_dj) begin
                pop_expect(K_JDONE, e);
                if (e.kind == K_JDONE) begin
                    chk("verdict", int'(node_index_valid), e.a);
                    chk("ref_node", int'(ref_node), e.b);
                    chk("ref_node_valid", int'(ref_node_valid), e.c);
                end
            end
        end
        prev_rd <= data_reset_done;
        prev_dj <= done_judge;
    end

    // Clear sweep; nwr < MAX_NODES drops go_reset_data after nwr writes.
    task automatic do_clear(input int nwr, input bit with_judge);
        bit full;
        full = (nwr >= MAX_NODES);
        for (int a = 0; a < (full ? MAX_NODES : nwr); a++) push(K_WR, a, 0, 0);
        if (full) push(K_RDONE, 0, 0, 0);
        m_ref = 0;
        m_refv = 0;
        go_reset_data = 1'b1;
        go_judge_valid = with_judge;
        @(posedge clk); #1;
        chk("clear_started", int'(dist_wr_en), 1);
        chk("clear_clears_refv", int'(ref_node_valid), 0);
        if (full) begin
            repeat (MAX_NODES) @(posedge clk);
            #1 chk("reset_done", int'(data_reset_done), 1);
            repeat (2) @(posedge clk);
            #1 chk("reset_done_held", int'(data_reset_done), 1);
            go_reset_data = 1'b0;
            go_judge_valid = 1'b0;
            @(posedge clk); #1;
            chk("reset_done_drop", int'(data_reset_done), 0);
        end else begin
            repeat (nwr - 1) @(posedge clk);
            #1 go_reset_data = 1'b0;
            go_judge_valid = 1'b0;
            @(posedge clk); #1;
            chk("abort_no_write", int'(dist_wr_en), 0);
            repeat (2) @(posedge clk);
            #1 chk("abort_no_done", int'(data_reset_done), 0);
        end
        chk("busy_idle", int'(busy), 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic do_judge(input int cnt, input int ex, input int idx, input bit abort_exist);
        bit v;
        v = (cnt != 0) && (idx < cnt) && ex[idx];
        node_count    = (IDX_W + 1)'(cnt);
        node_exists   = MAX_NODES'(ex);
        node_in       = IDX_W'(idx);
        ld_node_index = 1'b1;
        @(posedge clk); #1;
        ld_node_index = 1'b0;
        node_in = IDX_W'($urandom_range(0, MAX_NODES - 1));
        go_judge_valid = 1'b1;
        @(posedge clk); #1;
        chk("judge_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("judge_not_done_yet", int'(done_judge), 0);
        if (abort_exist) begin
            go_judge_valid = 1'b0;
            @(posedge clk); #1;
            chk("abort_no_done", int'(done_judge), 0);
            chk("abort_ref_kept", int'(ref_node), m_ref);
            chk("abort_refv_kept", int'(ref_node_valid), m_refv);
        end else begin
            if (v) begin
                m_ref = idx;
                m_refv = 1;
            end
            push(K_JDONE, int'(v), m_ref, m_refv);
            @(posedge clk); #1;
            chk("judge_latency", int'(done_judge), 1);
            @(posedge clk); #1;
            chk("done_held", int'(done_judge), 1);
            go_judge_valid = 1'b0;
            @(posedge clk); #1;
            chk("done_drop", int'(done_judge), 0);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdone"}, int'(data_reset_done), 0);
        chk({tag, "_djudge"}, int'(done_judge), 0);
        chk({tag, "_verdict"}, int'(node_index_valid), 0);
        chk({tag, "_ref"}, int'(ref_node), 0);
        chk({tag, "_refv"}, int'(ref_node_valid), 0);
        chk({tag, "_wren"}, int'(dist_wr_en), 0);
        chk({tag, "_wraddr"}, int'(dist_wr_addr), 0);
        chk({tag, "_wrdata"}, int'(dist_wr_data), INF);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset_mid_clear();
        for (int a = 0; a < 4; a++) push(K_WR, a, 0, 0);
        go_reset_data = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #7 program_resetn = 1'b0;
        #1 check_all_zero("async_rst");
        m_ref = 0;
        m_refv = 0;
        go_reset_data = 1'b0;
        @(negedge clk);
        program_resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_wren", int'(dist_wr_en), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, cnt, idx;
        program_resetn = 1'b0;
        go_reset_data  = 1'b0;
        ld_node_index  = 1'b0;
        go_judge_valid = 1'b0;
        node_in        = '0;
        node_count     = '0;
        node_exists    = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        program_resetn = 1'b1;
        @(posedge clk); #1;

        do_clear(16, 1'b0);
        do_judge(5, 'h001F, 3, 1'b0);
        do_judge(5, 'h001F, 7, 1'b0);
        do_judge(5, 'h0017, 3, 1'b0);
        do_judge(0, 'hFFFF, 0, 1'b0);
        do_clear(6, 1'b0);
        do_judge(5, 'h001F, 2, 1'b0);
        do_judge(5, 'h001F, 4, 1'b1);
        do_clear(16, 1'b1);
        do_judge(16, 'h8000, 15, 1'b0);
        do_reset_mid_clear();

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                cnt = $urandom_range(0, MAX_NODES);
                idx = $urandom_range(0, MAX_NODES - 1);
                if (cnt > 0 && $urandom_range(0, 1) == 1) idx = $urandom_range(0, cnt - 1);
                do_judge(cnt, int'($urandom), idx, r == 6);
            end else begin
                do_clear($urandom_range(1, MAX_NODES), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
